// File: rtl/l2_tag_hs_monitor.sv
// Valid/ready protocol monitor for the L2 tag bank streaming ports.
// Per channel: transfer counting and sticky drop/data/timeout errors, plus first-error capture.
module l2_tag_hs_monitor #(
  parameter int NCH    = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  parameter int TO_W   = 8,
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        valid,
  input  logic [NCH-1:0]        ready,
  input  logic [NCH*DATA_W-1:0] data,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [TO_W-1:0]       timeout_limit,
  input  logic [SEL_W-1:0]      cnt_sel,
  output logic [CNT_W-1:0]      cnt_out,
  output logic [NCH-1:0]        err_drop,
  output logic [NCH-1:0]        err_data,
  output logic [NCH-1:0]        err_timeout,
  output logic                  err_any,
  output logic                  first_err_valid,
  output logic [SEL_W-1:0]      first_err_ch
);

  // state | meaning
  // IDLE  | no beat outstanding on the channel
  // PEND  | valid seen without ready; payload held for stability check
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} ch_state_t;

  ch_state_t         state     [NCH];
  logic [DATA_W-1:0] hold_data [NCH];
  logic [TO_W-1:0]   stall_cnt [NCH];
  logic [CNT_W-1:0]  xfer_cnt  [NCH];

  logic [TO_W-1:0]  stall_nxt [NCH];
  logic [NCH-1:0]   set_drop;
  logic [NCH-1:0]   set_data;
  logic [NCH-1:0]   set_to;
  logic [NCH-1:0]   set_vec;
  logic [SEL_W-1:0] first_idx;

  always_comb begin
    set_drop  = '0;
    set_data  = '0;
    set_to    = '0;
    first_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      stall_nxt[i] = (stall_cnt[i] == '1) ? stall_cnt[i] : stall_cnt[i] + 1'b1;
      set_drop[i]  = (state[i] == PEND) && !valid[i];
      set_data[i]  = (state[i] == PEND) && valid[i] && (data[i*DATA_W +: DATA_W] != hold_data[i]);
      set_to[i]    = valid[i] && !ready[i] && (timeout_limit != '0) && (stall_nxt[i] == timeout_limit);
    end
    set_vec = set_drop | set_data | set_to;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (set_vec[i]) first_idx = SEL_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]     <= IDLE;
        hold_data[i] <= '0;
        stall_cnt[i] <= '0;
        xfer_cnt[i]  <= '0;
      end
      err_drop        <= '0;
      err_data        <= '0;
      err_timeout     <= '0;
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
    end else if (clear) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]     <= IDLE;
        hold_data[i] <= '0;
        stall_cnt[i] <= '0;
        xfer_cnt[i]  <= '0;
      end
      err_drop        <= '0;
      err_data        <= '0;
      err_timeout     <= '0;
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
    end else if (!enable) begin
      // Dropping the FSMs to IDLE keeps a re-enable mid-beat from flagging a drop.
      for (int i = 0; i < NCH; i++) begin
        state[i]     <= IDLE;
        stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (valid[i] && !ready[i]) begin
          stall_cnt[i] <= stall_nxt[i];
          if (state[i] == IDLE) begin
            state[i]     <= PEND;
            hold_data[i] <= data[i*DATA_W +: DATA_W];
          end
        end else begin
          stall_cnt[i] <= '0;
          state[i]     <= IDLE;
        end
        if (valid[i] && ready[i] && (xfer_cnt[i] != '1)) xfer_cnt[i] <= xfer_cnt[i] + 1'b1;
      end
      err_drop    <= err_drop | set_drop;
      err_data    <= err_data | set_data;
      err_timeout <= err_timeout | set_to;
      if (!first_err_valid && (set_vec != '0)) begin
        first_err_valid <= 1'b1;
        first_err_ch    <= first_idx;
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < NCH) cnt_out = xfer_cnt[cnt_sel];
  end

  assign err_any = |{err_drop, err_data, err_timeout};

endmodule

// File: tb/tb_l2_tag_hs_monitor.sv
// Bench for l2_tag_hs_monitor: directed scenarios then random traffic against a
// transaction-level reference model; a second instance uses a 4-bit counter for saturation.
module tb_l2_tag_hs_monitor;

  localparam int NCH = 8;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    valid, ready;
  logic [127:0]  data;
  logic          enable, clear;
  logic [7:0]    limit;
  logic [2:0]    cnt_sel;
  logic [15:0]   cnt_out;
  logic [3:0]    cnt_out_s;
  logic [7:0]    err_drop, err_data, err_timeout;
  logic [7:0]    s_drop, s_data, s_to;
  logic          err_any, s_any, first_err_valid, s_fv;
  logic [2:0]    first_err_ch, s_fch;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_pend [NCH];
  logic [15:0] m_hold [NCH];
  int          m_stall [NCH];
  int          m_cnt [NCH];
  logic [7:0]  m_drop, m_data, m_to;
  bit          m_fv;
  int          m_fch;

  always #5 clk = ~clk;

  l2_tag_hs_monitor #(.NCH(8), .DATA_W(16), .CNT_W(16), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .data(data),
    .enable(enable), .clear(clear), .timeout_limit(limit), .cnt_sel(cnt_sel),
    .cnt_out(cnt_out), .err_drop(err_drop), .err_data(err_data),
    .err_timeout(err_timeout), .err_any(err_any),
    .first_err_valid(first_err_valid), .first_err_ch(first_err_ch));

  l2_tag_hs_monitor #(.NCH(8), .DATA_W(16), .CNT_W(4), .TO_W(8)) dut_s (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .data(data),
    .enable(enable), .clear(clear), .timeout_limit(limit), .cnt_sel(cnt_sel),
    .cnt_out(cnt_out_s), .err_drop(s_drop), .err_data(s_data),
    .err_timeout(s_to), .err_any(s_any),
    .first_err_valid(s_fv), .first_err_ch(s_fch));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c, input int w);
    return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = 0; m_hold[i] = '0; m_stall[i] = 0; m_cnt[i] = 0;
    end
    m_drop = '0; m_data = '0; m_to = '0; m_fv = 0; m_fch = 0;
  endtask

  // A channel is pending exactly when its previous enabled edge was a stall.
  task automatic model_edge();
    logic [7:0] nd, nda, nt, nv;
    nd = '0; nda = '0; nt = '0;
    if (clear) begin
      model_reset();
      return;
    end
    if (!enable) begin
      for (int i = 0; i < NCH; i++) begin m_pend[i] = 0; m_stall[i] = 0; end
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      logic [15:0] d;
      d = data[i*DW +: DW];
      if (m_pend[i] && !valid[i]) nd[i] = 1'b1;
      if (m_pend[i] && valid[i] && d != m_hold[i]) nda[i] = 1'b1;
      if (valid[i] && !ready[i]) begin
        m_stall[i] = (m_stall[i] < 255) ? m_stall[i] + 1 : 255;
        if (limit != 0 && m_stall[i] == int'(limit)) nt[i] = 1'b1;
        if (!m_pend[i]) m_hold[i] = d;
        m_pend[i] = 1;
      end else begin
        m_stall[i] = 0;
        m_pend[i]  = 0;
      end
      if (valid[i] && ready[i]) m_cnt[i]++;
    end
    nv = nd | nda | nt;
    m_drop |= nd; m_data |= nda; m_to |= nt;
    if (!m_fv && nv != 0) begin
      m_fv = 1;
      for (int i = NCH - 1; i >= 0; i--) if (nv[i]) m_fch = i;
    end
  endtask

  task automatic check_all();
    chk("err_drop", err_drop, m_drop);
    chk("err_data", err_data, m_data);
    chk("err_timeout", err_timeout, m_to);
    chk("err_any", err_any, (m_drop | m_data | m_to) != 0);
    chk("first_err_valid", first_err_valid, m_fv);
    chk("first_err_ch", first_err_ch, m_fch);
    chk("cnt_out", cnt_out, sat(m_cnt[cnt_sel], 16));
    chk("cnt_out_sat4", cnt_out_s, sat(m_cnt[cnt_sel], 4));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_ch(input int ch, input logic v, input logic r, input logic [15:0] d);
    valid[ch] = v;
    ready[ch] = r;
    data[ch*DW +: DW] = d;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = '0; ready = '0; data = '0;
    enable = 1'b1; clear = 1'b0; limit = 8'd4; cnt_sel = 3'd3;
    model_reset();
    #2;
    check_all();
    rst = 1'b0;

    // clean traffic on ch3
    for (int k = 0; k < 5; k++) begin set_ch(3, 1, 1, 16'(k)); tick(); end
    set_ch(3, 0, 0, 0);
    tick();
    chk("clean_cnt", cnt_out, 5);
    chk("clean_any", err_any, 0);
    chk("clean_fv", first_err_valid, 0);

    // drop on ch2
    set_ch(2, 1, 0, 16'h1234); tick(); tick();
    set_ch(2, 0, 0, 16'h1234); tick();
    chk("drop_vec", err_drop, 8'h04);
    chk("drop_fch", first_err_ch, 2);
    chk("drop_fv", first_err_valid, 1);
    chk("drop_any", err_any, 1);
    do_clear();
    chk("clear_any", err_any, 0);

    // data change on ch5 then drop on ch1
    set_ch(5, 1, 0, 16'hA5A5); tick();
    set_ch(5, 1, 0, 16'h5A5A); tick();
    set_ch(1, 1, 0, 16'h0001); tick(); tick();
    set_ch(1, 0, 0, 16'h0001); tick();
    chk("order_data", err_data, 8'h20);
    chk("order_drop", err_drop, 8'h02);
    chk("order_fch", first_err_ch, 5);
    set_ch(5, 0, 0, 0);
    tick();
    do_clear();

    // timeout boundary on ch0
    limit = 8'd3;
    set_ch(0, 1, 0, 16'h0F0F); tick(); tick();
    chk("to_edge2", err_timeout, 8'h00);
    tick();
    chk("to_edge3", err_timeout, 8'h01);
    set_ch(0, 0, 0, 0);
    do_clear();
    limit = 8'd0;
    set_ch(0, 1, 0, 16'h0F0F);
    for (int k = 0; k < 300; k++) tick();
    chk("to_disabled", err_timeout, 8'h00);
    set_ch(0, 0, 0, 0);
    limit = 8'd4;
    tick();

    // saturation on ch7
    cnt_sel = 3'd7;
    for (int k = 0; k < 20; k++) begin set_ch(7, 1, 1, 16'(k)); tick(); end
    set_ch(7, 0, 0, 0);
    tick();
    chk("sat_cnt4", cnt_out_s, 15);
    chk("sat_cnt16", cnt_out, 20);

    // async reset mid-stall
    set_ch(3, 1, 0, 16'hBEEF); tick();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_cnt", cnt_out, 0);
    set_ch(3, 0, 0, 0);
    #1 rst = 1'b0;

    // enable dropped during a stall
    set_ch(4, 1, 0, 16'h4444); tick(); tick();
    enable = 1'b0; tick();
    enable = 1'b1; set_ch(4, 0, 0, 16'h4444); tick();
    chk("reenable_drop", err_drop, 8'h00);

    // clear with errors set
    set_ch(6, 1, 0, 16'h6666); tick();
    set_ch(6, 0, 0, 16'h6666); tick();
    chk("pre_clear_drop", err_drop, 8'h40);
    do_clear();
    chk("post_clear_any", err_any, 0);
    chk("post_clear_fv", first_err_valid, 0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      valid   = 8'($urandom);
      ready   = 8'($urandom) | 8'($urandom);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(7) == 0) data[i*DW +: DW] = 16'($urandom_range(3));
      enable  = ($urandom_range(15) != 0);
      clear   = ($urandom_range(40) == 0);
      if (clear) limit = 8'($urandom_range(6));
      cnt_sel = 3'($urandom);
      tick();
    end
    clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
